// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: registered execute-stage ALU. Single-cycle ops complete on the
// accept edge; multiply (shift-add) and divide (restoring) iterate WIDTH steps.
module seq_alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             sign,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned W1  = WIDTH + 1;
    localparam int unsigned W2  = 2 * WIDTH;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4, OP_SRL = 4'h5, OP_SRA = 4'h6, OP_ROL = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8, OP_OR  = 4'h9, OP_XOR = 4'hA, OP_NOR = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_SLT = 4'hE, OP_SEQ = 4'hF;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [3:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, mb_q, mb_d, acc_q, acc_d, lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
    logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;

    logic [W1-1:0]    add_sum;
    logic [WIDTH-1:0] sub_diff, sc_res, a_mag, b_mag;
    logic [SHW-1:0]   shamt;
    logic [W2-1:0]    rol_tmp;
    logic             lt, sc_ovf;

    // Single-cycle results and operand magnitudes, all from the live request
    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b} + W1'(carry_in);
        sub_diff = a - b;
        shamt    = b[SHW-1:0];
        rol_tmp  = {a, a} << shamt;
        lt       = sign ? ($signed(a) < $signed(b)) : (a < b);
        a_mag    = (sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag    = (sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        sc_res   = '0;
        sc_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_ovf = sign ? ((a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]))
                              : add_sum[WIDTH];
            end
            OP_SUB: begin
                sc_res = sub_diff;
                sc_ovf = sign ? ((a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]))
                              : (a < b);
            end
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = $signed(a) >>> shamt;
            OP_ROL:  sc_res = rol_tmp[W2-1:WIDTH];
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_NAND: sc_res = ~(a & b);
            OP_XNOR: sc_res = ~(a ^ b);
            OP_SLT:  sc_res = WIDTH'(lt);
            OP_SEQ:  sc_res = WIDTH'(a == b);
            default: sc_res = '0;
        endcase
    end

    logic [W1-1:0]    mul_sum, rem_sh, div_diff;
    logic [WIDTH-1:0] step_acc, step_lo, fin_lo, fin_hi;
    logic [W2-1:0]    prod;
    logic             fin_ovf, fin_dz;

    // One iteration step (acc = partial product high / remainder, lo = multiplier / quotient)
    // followed by the sign fix-up used on the final step
    always_comb begin
        mul_sum  = {1'b0, acc_q} + {1'b0, mb_q};
        rem_sh   = {acc_q, lo_q[WIDTH-1]};
        div_diff = rem_sh - {1'b0, mb_q};
        step_acc = acc_q;
        step_lo  = lo_q;
        prod     = '0;
        fin_lo   = '0;
        fin_hi   = '0;
        fin_ovf  = 1'b0;
        fin_dz   = 1'b0;
        if (op_q == OP_MUL) begin
            if (lo_q[0]) {step_acc, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
            else         {step_acc, step_lo} = {1'b0, acc_q, lo_q[WIDTH-1:1]};
            prod = {step_acc, step_lo};
            if (sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) prod = ~prod + W2'(1);
            fin_lo  = prod[WIDTH-1:0];
            fin_hi  = prod[W2-1:WIDTH];
            fin_ovf = sign_q ? (fin_hi != {WIDTH{fin_lo[WIDTH-1]}}) : (fin_hi != '0);
        end else begin
            if (!div_diff[WIDTH]) begin
                step_acc = div_diff[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = rem_sh[WIDTH-1:0];
                step_lo  = {lo_q[WIDTH-2:0], 1'b0};
            end
            if (b_q == '0) begin
                fin_lo = '1;
                fin_hi = a_q;
                fin_dz = 1'b1;
            end else begin
                fin_lo  = (sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (~step_lo + WIDTH'(1)) : step_lo;
                fin_hi  = (sign_q && a_q[WIDTH-1]) ? (~step_acc + WIDTH'(1)) : step_acc;
                fin_ovf = sign_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op_d        = op_q;
        sign_d      = sign_q;
        a_d         = a_q;
        b_d         = b_q;
        mb_d        = mb_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        result_d    = result_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d       = op;
                    sign_d     = sign;
                    a_d        = a;
                    b_d        = b;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (op == OP_MUL || op == OP_DIV) begin
                        state_d = CALC;
                        count_d = '0;
                        acc_d   = '0;
                        lo_d    = a_mag;
                        mb_d    = b_mag;
                    end else begin
                        state_d     = DONE;
                        result_d    = sc_res;
                        hi_d        = '0;
                        zero_d      = (sc_res == '0);
                        ovf_d       = sc_ovf;
                        dz_d        = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            CALC: begin
                acc_d   = step_acc;
                lo_d    = step_lo;
                count_d = count_q + SHW'(1);
                if (count_q == SHW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    result_d    = fin_lo;
                    hi_d        = fin_hi;
                    zero_d      = (fin_lo == '0);
                    ovf_d       = fin_ovf;
                    dz_d        = fin_dz;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            op_q        <= '0;
            sign_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mb_q        <= mb_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dz_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_seq_alu_muldiv.sv
// Self-checking bench for seq_alu_muldiv: directed corner cases plus random
// requests compared against a plain-arithmetic reference model.
module tb_seq_alu_muldiv;
    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic          sign;
    logic          carry_in;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  hi;
    logic          zero;
    logic          overflow;
    logic          div_by_zero;
    logic          busy;

    int n_chk;
    int n_bad;

    seq_alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sign(sign), .carry_in(carry_in), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .hi(hi),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic out_s32(input longint t);
        return (t < -64'sd2147483648) || (t > 64'sd2147483647);
    endfunction

    // Reference: plain integer arithmetic on 64-bit values
    function automatic void model(input logic [3:0] o, input logic sg, input logic ci,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [W-1:0] h,
                                  output logic v, output logic dz);
        longint sx, sy, t, rm;
        int     sh;
        sx = sg ? longint'($signed(x)) : longint'({32'h0, x});
        sy = sg ? longint'($signed(y)) : longint'({32'h0, y});
        sh = int'(y[4:0]);
        r = '0; h = '0; v = 1'b0; dz = 1'b0;
        case (o)
            4'h0: begin t = sx + sy + longint'(ci); r = t[31:0]; v = sg ? out_s32(t) : (t > 64'sd4294967295); end
            4'h1: begin t = sx - sy; r = t[31:0]; v = sg ? out_s32(t) : (t < 0); end
            4'h2: begin t = sx * sy; r = t[31:0]; h = t[63:32]; v = sg ? out_s32(t) : (h != 0); end
            4'h3: begin
                if (y == 0) begin
                    r = '1; h = x; dz = 1'b1;
                end else begin
                    t = sx / sy; rm = sx % sy;
                    r = t[31:0]; h = rm[31:0];
                    v = sg && (t > 64'sd2147483647);
                end
            end
            4'h4: r = x << sh;
            4'h5: r = x >> sh;
            4'h6: begin t = longint'($signed(x)) >>> sh; r = t[31:0]; end
            4'h7: begin r = x; repeat (sh) r = {r[W-2:0], r[W-1]}; end
            4'h8: r = x & y;
            4'h9: r = x | y;
            4'hA: r = x ^ y;
            4'hB: r = ~(x | y);
            4'hC: r = ~(x & y);
            4'hD: r = ~(x ^ y);
            4'hE: r = (sx < sy) ? 32'd1 : 32'd0;
            default: r = (x == y) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Issue one request, hold junk on the inputs while busy, then drain after 'stall' cycles
    task automatic run_op(input logic [3:0] o, input logic sg, input logic ci,
                          input logic [W-1:0] x, input logic [W-1:0] y, input int stall);
        logic [W-1:0] er, eh;
        logic         ev, ed;
        int           cyc, elat;
        model(o, sg, ci, x, y, er, eh, ev, ed);
        elat = (o == 4'h2 || o == 4'h3) ? W + 1 : 1;
        check("idle_ready", in_ready, 1);
        op = o; sign = sg; carry_in = ci; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        op = 4'($urandom); a = $urandom; b = $urandom; sign = 1'($urandom); carry_in = 1'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            check("busy_hi", busy, 1);
            check("ready_lo", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, elat);
        for (int s = 0; s <= stall; s++) begin
            check("out_valid", out_valid, 1);
            check("result", result, er);
            check("hi", hi, eh);
            check("zero", zero, (er == 0));
            check("overflow", overflow, ev);
            check("div_by_zero", div_by_zero, ed);
            check("ready_done", in_ready, 0);
            if (s < stall) begin @(posedge clk); #1; end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_clr", out_valid, 0);
        check("ready_back", in_ready, 1);
        check("busy_clr", busy, 0);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_chk = 0; n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; sign = 1'b0; carry_in = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_hi", hi, 0);
        check("rst_flags", {zero, overflow, div_by_zero}, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", in_ready, 1);

        run_op(4'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 0);
        run_op(4'h2, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(4'h3, 1'b0, 1'b0, 32'd100, 32'd7, 0);
        run_op(4'h3, 1'b0, 1'b0, 32'd9, 32'd0, 0);
        run_op(4'h3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(4'h3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(4'h3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0, 1);
        run_op(4'h2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        run_op(4'hA, 1'b0, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 5);
        run_op(4'h1, 1'b0, 1'b0, 32'd3, 32'd4, 0);
        run_op(4'h1, 1'b1, 1'b0, 32'h8000_0000, 32'd1, 0);
        run_op(4'h6, 1'b0, 1'b0, 32'h8000_00F0, 32'd4, 0);
        run_op(4'h7, 1'b0, 1'b0, 32'h8000_0001, 32'd0, 0);
        run_op(4'h7, 1'b0, 1'b0, 32'h8000_0001, 32'd1, 0);
        run_op(4'hE, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'hE, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);

        // Abort a multiply partway through with reset
        op = 4'h2; sign = 1'b1; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'h0, 1'b0, 1'b0, 32'd2, 32'd3, 0);

        for (int i = 0; i < 300; i++) begin
            run_op(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), pick(), pick(),
                   $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
